mem_port_arbiter: RTL and testbench

//  Shares one memory port between the CPU instruction-fetch (IFU) and load/store (LSU) requesters.

---
 rtl/mem_arb_pkg.sv | 20 ++
 rtl/mem_arb_sel.sv | 33 +++
 rtl/mem_port_arbiter.sv | 157 +++++++++++++++
 tb/tb_mem_port_arbiter.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the IFU/LSU memory port arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;
    localparam int unsigned DEF_WOP_W  = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_e;

    typedef enum logic {
        OWN_IFU = 1'b0,
        OWN_LSU = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arb_sel.sv
// Combinational grant between IFU and LSU requests.
// MEM_ARB_RR_EN selects round-robin on contention; otherwise LSU has fixed priority.
module mem_arb_sel
    import mem_arb_pkg::*;
(
`ifdef MEM_ARB_RR_EN
    input  owner_e last_grant,
`endif
    input  logic   ifu_valid,
    input  logic   lsu_valid,
    output logic   gnt_ifu_c,
    output logic   gnt_lsu_c
);

    always_comb begin
        gnt_ifu_c = ifu_valid && !lsu_valid;
        gnt_lsu_c = lsu_valid && !ifu_valid;
        if (ifu_valid && lsu_valid) begin
`ifdef MEM_ARB_RR_EN
            // Contention goes to whichever side was not granted last.
            if (last_grant == OWN_LSU) begin
                gnt_ifu_c = 1'b1;
            end else begin
                gnt_lsu_c = 1'b1;
            end
`else
            // LSU wins so a blocked load can never starve behind fetch.
            gnt_lsu_c = 1'b1;
`endif
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between IFU and LSU, one transaction outstanding at a time.
// Define MEM_ARB_RR_EN for round-robin contention handling (default: LSU priority).
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = DEF_ADDR_W,
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned WOP_W  = DEF_WOP_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req_valid,
    output logic              ifu_req_ready,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_rsp_valid,
    input  logic              ifu_rsp_ready,
    output logic [DATA_W-1:0] ifu_rsp_data,
    input  logic              lsu_req_valid,
    output logic              lsu_req_ready,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic              lsu_wen,
    input  logic [WOP_W-1:0]  lsu_wop,
    input  logic [DATA_W-1:0] lsu_wdata,
    output logic              lsu_rsp_valid,
    input  logic              lsu_rsp_ready,
    output logic [DATA_W-1:0] lsu_rsp_data,
    output logic              mem_req_valid,
    input  logic              mem_req_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_wen,
    output logic [WOP_W-1:0]  mem_wop,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_rsp_valid,
    output logic              mem_rsp_ready,
    input  logic [DATA_W-1:0] mem_rsp_data,
    output logic              busy
);

    state_e            state_q, state_d;
    owner_e            owner_q;
    logic [DATA_W-1:0] rdata_q;
    logic              gnt_ifu_c, gnt_lsu_c;
    logic              ifu_acc_c, lsu_acc_c;

`ifdef MEM_ARB_RR_EN
    owner_e last_grant_q;
`endif

    mem_arb_sel u_sel (
`ifdef MEM_ARB_RR_EN
        .last_grant (last_grant_q),
`endif
        .ifu_valid  (ifu_req_valid),
        .lsu_valid  (lsu_req_valid),
        .gnt_ifu_c  (gnt_ifu_c),
        .gnt_lsu_c  (gnt_lsu_c)
    );

    assign ifu_acc_c    = ifu_req_valid && ifu_req_ready;
    assign lsu_acc_c    = lsu_req_valid && lsu_req_ready;
    assign busy         = (state_q != IDLE);
    assign ifu_rsp_data = rdata_q;
    assign lsu_rsp_data = rdata_q;

    // Next state and handshake outputs; everything held low while in reset.
    always_comb begin
        state_d       = state_q;
        ifu_req_ready = 1'b0;
        lsu_req_ready = 1'b0;
        mem_req_valid = 1'b0;
        mem_rsp_ready = 1'b0;
        ifu_rsp_valid = 1'b0;
        lsu_rsp_valid = 1'b0;
        if (rst) begin
            case (state_q)
                IDLE: begin
                    ifu_req_ready = gnt_ifu_c;
                    lsu_req_ready = gnt_lsu_c;
                    if (gnt_ifu_c || gnt_lsu_c) begin
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    mem_req_valid = 1'b1;
                    if (mem_req_ready) begin
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    mem_rsp_ready = 1'b1;
                    if (mem_rsp_valid) begin
                        state_d = RESP;
                    end
                end
                RESP: begin
                    if (owner_q == OWN_IFU) begin
                        ifu_rsp_valid = 1'b1;
                        if (ifu_rsp_ready) begin
                            state_d = IDLE;
                        end
                    end else begin
                        lsu_rsp_valid = 1'b1;
                        if (lsu_rsp_ready) begin
                            state_d = IDLE;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State, latched request fields and captured response data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            owner_q   <= OWN_IFU;
            mem_addr  <= '0;
            mem_wen   <= 1'b0;
            mem_wop   <= '0;
            mem_wdata <= '0;
            rdata_q   <= '0;
        end else begin
            state_q <= state_d;
            if (ifu_acc_c) begin
                owner_q   <= OWN_IFU;
                mem_addr  <= ifu_addr;
                mem_wen   <= 1'b0;
                mem_wop   <= '0;
                mem_wdata <= '0;
            end else if (lsu_acc_c) begin
                owner_q   <= OWN_LSU;
                mem_addr  <= lsu_addr;
                mem_wen   <= lsu_wen;
                mem_wop   <= lsu_wop;
                mem_wdata <= lsu_wdata;
            end
            if (mem_rsp_valid && mem_rsp_ready) begin
                rdata_q <= mem_rsp_data;
            end
        end
    end

`ifdef MEM_ARB_RR_EN
    // Round-robin pointer moves only on an accepted request.
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_q <= OWN_IFU;
        end else if (ifu_acc_c) begin
            last_grant_q <= OWN_IFU;
        end else if (lsu_acc_c) begin
            last_grant_q <= OWN_LSU;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: stimulus pushes expectations, a negedge monitor pops and compares.
module tb_mem_port_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned OW = 3;

    typedef struct {
        bit          chk;
        logic [31:0] data;
    } exp_rsp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ifu_req_valid, ifu_req_ready, ifu_rsp_valid, ifu_rsp_ready;
    logic [AW-1:0] ifu_addr;
    logic [DW-1:0] ifu_rsp_data;
    logic          lsu_req_valid, lsu_req_ready, lsu_wen, lsu_rsp_valid, lsu_rsp_ready;
    logic [AW-1:0] lsu_addr;
    logic [OW-1:0] lsu_wop;
    logic [DW-1:0] lsu_wdata, lsu_rsp_data;
    logic          mem_req_valid, mem_req_ready, mem_wen, mem_rsp_valid, mem_rsp_ready;
    logic [AW-1:0] mem_addr;
    logic [OW-1:0] mem_wop;
    logic [DW-1:0] mem_wdata, mem_rsp_data;
    logic          busy;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    exp_rsp_t     q_ifu[$];
    exp_rsp_t     q_lsu[$];
    logic [67:0]  q_mem[$];

    bit            mem_manual = 1'b0;
    int            stall = 0;
    bit            req_hs = 1'b0;
    bit            rsp_hs = 1'b0;
    logic [AW-1:0] req_addr;

    mem_port_arbiter dut (
        .clk(clk), .rst(rst),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready), .ifu_rsp_data(ifu_rsp_data),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
        .lsu_wen(lsu_wen), .lsu_wop(lsu_wop), .lsu_wdata(lsu_wdata),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready), .lsu_rsp_data(lsu_rsp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
        .mem_wen(mem_wen), .mem_wop(mem_wop), .mem_wdata(mem_wdata),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_ready(mem_rsp_ready), .mem_rsp_data(mem_rsp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        case (a)
            32'h8000_0000: mem_data = 32'h0010_0073;
            32'h8000_0004: mem_data = 32'h0000_0013;
            32'h8000_1000: mem_data = 32'h1234_5678;
            32'h8000_1008: mem_data = 32'hCAFE_F00D;
            default:       mem_data = 32'h0;
        endcase
    endfunction

    // Memory model: ready after `stall` cycles, response one cycle after the request handshake.
    initial begin
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = '0;
        req_addr      = '0;
        forever begin
            tick();
            if (mem_manual) begin
                req_hs = 1'b0;
                rsp_hs = 1'b0;
            end else begin
                if (rsp_hs) begin
                    mem_rsp_valid = 1'b0;
                    rsp_hs        = 1'b0;
                end
                if (req_hs) begin
                    mem_rsp_valid = 1'b1;
                    mem_rsp_data  = mem_data(req_addr);
                    req_hs        = 1'b0;
                end
                if (mem_rsp_valid && mem_rsp_ready) rsp_hs = 1'b1;
            end
            mem_req_ready = 1'b0;
            if (mem_req_valid) begin
                if (stall > 0) begin
                    stall--;
                end else begin
                    mem_req_ready = 1'b1;
                    req_hs        = 1'b1;
                    req_addr      = mem_addr;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every response and memory-request handshake.
    initial begin
        exp_rsp_t    e;
        logic [67:0] m;
        forever begin
            @(negedge clk);
            if (rst === 1'b1) begin
                if (ifu_rsp_valid && lsu_rsp_valid) check("rsp_exclusive", 1, 0);
                if (ifu_rsp_valid && ifu_rsp_ready) begin
                    if (q_ifu.size() == 0) check("ifu_rsp_unexpected", 1, 0);
                    else begin
                        e = q_ifu.pop_front();
                        if (e.chk) check("ifu_rsp_data", 128'(ifu_rsp_data), 128'(e.data));
                    end
                end
                if (lsu_rsp_valid && lsu_rsp_ready) begin
                    if (q_lsu.size() == 0) check("lsu_rsp_unexpected", 1, 0);
                    else begin
                        e = q_lsu.pop_front();
                        if (e.chk) check("lsu_rsp_data", 128'(lsu_rsp_data), 128'(e.data));
                    end
                end
                if (mem_req_valid && mem_req_ready) begin
                    if (q_mem.size() == 0) check("mem_req_unexpected", 1, 0);
                    else begin
                        m = q_mem.pop_front();
                        check("mem_req_fields", 128'({mem_addr, mem_wen, mem_wop, mem_wdata}), 128'(m));
                    end
                end
            end
        end
    end

    task automatic ifu_go(input logic [31:0] a, output int acc);
        bit got = 1'b0;
        acc = -1;
        ifu_addr      = a;
        ifu_req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (ifu_req_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (got) begin
            tick();
            acc = cyc;
        end else begin
            check("ifu_grant_timeout", 1, 0);
        end
        ifu_req_valid = 1'b0;
    endtask

    task automatic lsu_go(input logic [31:0] a, input logic w, input logic [2:0] op,
                          input logic [31:0] d, output int acc);
        bit got = 1'b0;
        acc = -1;
        lsu_addr      = a;
        lsu_wen       = w;
        lsu_wop       = op;
        lsu_wdata     = d;
        lsu_req_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            #1;
            if (lsu_req_ready) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        if (got) begin
            tick();
            acc = cyc;
        end else begin
            check("lsu_grant_timeout", 1, 0);
        end
        lsu_req_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            tick();
            n++;
        end
        check(name, 128'(busy), 0);
    endtask

    initial begin
        int          acc, acc_i, acc_l, n, hs_cyc;
        logic [67:0] snap;
        rst           = 1'b0;
        ifu_req_valid = 1'b1;
        lsu_req_valid = 1'b1;
        ifu_addr      = 32'h8000_0000;
        lsu_addr      = 32'h8000_1000;
        lsu_wen       = 1'b0;
        lsu_wop       = '0;
        lsu_wdata     = '0;
        ifu_rsp_ready = 1'b1;
        lsu_rsp_ready = 1'b1;

        // Power-on reset with both requesters asserting: nothing may be granted.
        repeat (3) begin
            tick();
            check("init_rst_outs", 128'({busy, mem_req_valid, mem_rsp_ready, ifu_rsp_valid,
                                         lsu_rsp_valid, ifu_req_ready, lsu_req_ready}), 0);
        end
        check("init_rst_fields", 128'({mem_addr, mem_wen, mem_wop, mem_wdata}), 0);
        ifu_req_valid = 1'b0;
        lsu_req_valid = 1'b0;
        rst = 1'b1;
        tick();

        // IFU-only fetch, zero-wait memory.
        q_mem.push_back({32'h8000_0000, 1'b0, 3'b000, 32'h0});
        q_ifu.push_back('{1'b1, 32'h0010_0073});
        ifu_go(32'h8000_0000, acc);
        n = 0;
        while (!ifu_rsp_valid && n < 20) begin
            tick();
            n++;
        end
        check("ifu_latency", 128'(n), 2);
        check("ifu_only_lsu_quiet", 128'(lsu_rsp_valid), 0);
        wait_idle("ifu_only_done");

        // Store with stale LSU fields later kept around to catch IFU field leakage.
        q_mem.push_back({32'h8000_1004, 1'b1, 3'b010, 32'hDEAD_BEEF});
        q_lsu.push_back('{1'b0, 32'h0});
        lsu_go(32'h8000_1004, 1'b1, 3'b010, 32'hDEAD_BEEF, acc);
        wait_idle("store_done");

        // Reset while waiting on memory; the late response must be ignored.
        mem_manual = 1'b1;
        tick();
        q_mem.push_back({32'h8000_0000, 1'b0, 3'b000, 32'h0});
        ifu_go(32'h8000_0000, acc);
        n = 0;
        while (!mem_rsp_ready && n < 20) begin
            tick();
            n++;
        end
        check("reach_wait", 128'(mem_rsp_ready), 1);
        rst = 1'b0;
        repeat (3) begin
            tick();
            check("mid_rst_outs", 128'({busy, mem_req_valid, mem_rsp_ready, ifu_rsp_valid,
                                        lsu_rsp_valid, ifu_req_ready, lsu_req_ready}), 0);
        end
        check("mid_rst_fields", 128'({mem_addr, mem_wen, mem_wop, mem_wdata}), 0);
        rst           = 1'b1;
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = 32'hFFFF_FFFF;
        repeat (3) begin
            tick();
            check("late_rsp_ignored", 128'({ifu_rsp_valid, lsu_rsp_valid, mem_rsp_ready, busy}), 0);
        end
        mem_rsp_valid = 1'b0;
        mem_manual    = 1'b0;
        tick();

        // Contention right after reset: LSU wins in both modes, IFU follows.
        q_mem.push_back({32'h8000_1000, 1'b0, 3'b000, 32'h0});
        q_mem.push_back({32'h8000_0004, 1'b0, 3'b000, 32'h0});
        q_lsu.push_back('{1'b1, 32'h1234_5678});
        q_ifu.push_back('{1'b1, 32'h0000_0013});
        fork
            ifu_go(32'h8000_0004, acc_i);
            lsu_go(32'h8000_1000, 1'b0, 3'b000, 32'h0, acc_l);
        join
        check("contend1_lsu_first", 128'(acc_l < acc_i), 1);
        wait_idle("contend1_done");

        // Uncontested LSU load, then contention that separates the two modes.
        q_mem.push_back({32'h8000_1008, 1'b0, 3'b000, 32'h0});
        q_lsu.push_back('{1'b1, 32'hCAFE_F00D});
        lsu_go(32'h8000_1008, 1'b0, 3'b000, 32'h0, acc);
        wait_idle("lsu_solo_done");
`ifdef MEM_ARB_RR_EN
        q_mem.push_back({32'h8000_0000, 1'b0, 3'b000, 32'h0});
        q_mem.push_back({32'h8000_1000, 1'b0, 3'b000, 32'h0});
`else
        q_mem.push_back({32'h8000_1000, 1'b0, 3'b000, 32'h0});
        q_mem.push_back({32'h8000_0000, 1'b0, 3'b000, 32'h0});
`endif
        q_lsu.push_back('{1'b1, 32'h1234_5678});
        q_ifu.push_back('{1'b1, 32'h0010_0073});
        fork
            ifu_go(32'h8000_0000, acc_i);
            lsu_go(32'h8000_1000, 1'b0, 3'b000, 32'h0, acc_l);
        join
        wait_idle("contend2_done");

        // Backpressure on both memory request and IFU response, then back-to-back LSU grant.
        stall         = 5;
        ifu_rsp_ready = 1'b0;
        hs_cyc        = 0;
        q_mem.push_back({32'h8000_0004, 1'b0, 3'b000, 32'h0});
        q_mem.push_back({32'h8000_1008, 1'b0, 3'b000, 32'h0});
        q_ifu.push_back('{1'b1, 32'h0000_0013});
        q_lsu.push_back('{1'b1, 32'hCAFE_F00D});
        ifu_go(32'h8000_0004, acc_i);
        fork
            lsu_go(32'h8000_1008, 1'b0, 3'b000, 32'h0, acc_l);
            begin
                int k = 0;
                snap = {mem_addr, mem_wen, mem_wop, mem_wdata};
                while (mem_req_valid && k < 20) begin
                    check("bp_fields_stable", 128'({mem_addr, mem_wen, mem_wop, mem_wdata}), 128'(snap));
                    k++;
                    tick();
                end
                check("bp_issue_cycles", 128'(k), 6);
                k = 0;
                while (!ifu_rsp_valid && k < 20) begin
                    tick();
                    k++;
                end
                repeat (4) begin
                    check("bp_rsp_held", 128'({ifu_rsp_valid, lsu_req_ready}), 128'(2'b10));
                    tick();
                end
                hs_cyc        = cyc;
                ifu_rsp_ready = 1'b1;
            end
        join
        check("b2b_accept_cycle", 128'(acc_l), 128'(hs_cyc + 2));
        wait_idle("bp_done");

        n = 0;
        while ((q_ifu.size() + q_lsu.size() + q_mem.size()) != 0 && n < 50) begin
            tick();
            n++;
        end
        check("scoreboard_drained", 128'(q_ifu.size() + q_lsu.size() + q_mem.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
